// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package sipo_pkg;
    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic {IDLE, SHIFT} sipo_state_t;
endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, abort and parallel valid/ready bundle for sipo_deserializer.
interface sipo_deserializer_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             SIN;
    logic             SIN_VALID;
    logic             ABORT;
    logic [WIDTH-1:0] P_OUT;
    logic             P_VALID;
    logic             P_READY;
    logic             OVF;
    logic             BUSY;

    modport master (
        output SIN, SIN_VALID, ABORT, P_READY,
        input  P_OUT, P_VALID, OVF, BUSY
    );

    modport slave (
        input  SIN, SIN_VALID, ABORT, P_READY,
        output P_OUT, P_VALID, OVF, BUSY
    );
endinterface

// File: rtl/sipo_bit_counter.sv
// Counts accepted serial bits; tc marks the edge that accepts the last bit of a word.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic tc
);
    logic [CNT_W-1:0] count;

    assign tc = inc && (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || tc) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel converter with a held, double-buffered parallel output.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                CLK,
    input logic                RST_N,
    sipo_deserializer_if.slave bus
);
    sipo_state_t      state_q, state_d;
    logic             inc, tc, load;
    logic [WIDTH-1:0] cand;

    assign inc = bus.SIN_VALID && !bus.ABORT;

    sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (CLK),
        .rst_n(RST_N),
        .inc  (inc),
        .clr  (bus.ABORT),
        .tc   (tc)
    );

    // Only WIDTH-1 bits are ever stored; the final bit goes straight into the candidate word.
    if (WIDTH == 1) begin : g_w1
        assign cand = bus.SIN;
    end else begin : g_wn
        logic [WIDTH-2:0] sreg;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sreg <= '0;
            end else if (bus.ABORT) begin
                sreg <= '0;
            end else if (bus.SIN_VALID) begin
                sreg <= cand[WIDTH-2:0];
            end
        end

        assign cand = {sreg, bus.SIN};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.ABORT) begin
            state_d = IDLE;
        end else if (bus.SIN_VALID) begin
            state_d = tc ? IDLE : SHIFT;
        end
    end

    assign bus.BUSY = (state_q == SHIFT);

    // A completing word may refill the buffer on the same edge the consumer drains it.
    assign load = tc && (!bus.P_VALID || bus.P_READY);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.P_OUT   <= '0;
            bus.P_VALID <= 1'b0;
            bus.OVF     <= 1'b0;
        end else begin
            if (load) begin
                bus.P_OUT   <= cand;
                bus.P_VALID <= 1'b1;
            end else if (tc) begin
                bus.OVF <= 1'b1;
            end else if (bus.P_VALID && bus.P_READY) begin
                bus.P_VALID <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: directed scenarios plus random traffic against a word-level model.
module tb_sipo_deserializer;
    localparam int W = 3;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    sipo_deserializer_if #(.WIDTH(W)) bus ();

    sipo_deserializer #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model state: bits collected so far as a number, plus the output buffer.
    int unsigned m_n;
    int unsigned m_acc;
    int unsigned m_pout;
    bit          m_pv;
    bit          m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_acc = 0; m_pout = 0; m_pv = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        bit          done;
        int unsigned word;
        done = 0;
        word = 0;
        if (!RST_N) begin
            model_reset();
            return;
        end
        if (bus.ABORT) begin
            m_n = 0; m_acc = 0;
        end else if (bus.SIN_VALID) begin
            m_acc = m_acc * 2 + int'(bus.SIN);
            m_n++;
            if (m_n == W) begin
                done = 1; word = m_acc; m_n = 0; m_acc = 0;
            end
        end
        if (done) begin
            if (!m_pv || bus.P_READY) begin
                m_pout = word; m_pv = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (m_pv && bus.P_READY) begin
            m_pv = 0;
        end
    endtask

    task automatic compare_all();
        chk("p_out",   int'(bus.P_OUT),   int'(m_pout));
        chk("p_valid", int'(bus.P_VALID), int'(m_pv));
        chk("ovf",     int'(bus.OVF),     int'(m_ovf));
        chk("busy",    int'(bus.BUSY),    int'(m_n != 0));
    endtask

    // Drive one cycle of inputs, let the edge happen, then check DUT against model.
    task automatic step(input logic sin, input logic sv, input logic ab, input logic rdy);
        bus.SIN = sin; bus.SIN_VALID = sv; bus.ABORT = ab; bus.P_READY = rdy;
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
        @(negedge CLK);
    endtask

    task automatic bits3(input logic [2:0] b, input logic rdy);
        for (int i = 2; i >= 0; i--) step(b[i], 1'b1, 1'b0, rdy);
    endtask

    task automatic async_reset_check(input string tag);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        chk({tag, "_p_out"},   int'(bus.P_OUT),   0);
        chk({tag, "_p_valid"}, int'(bus.P_VALID), 0);
        chk({tag, "_ovf"},     int'(bus.OVF),     0);
        chk({tag, "_busy"},    int'(bus.BUSY),    0);
        @(negedge CLK);
        for (int i = 0; i < 3; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        RST_N = 1'b1;
    endtask

    initial begin
        bus.SIN = 0; bus.SIN_VALID = 0; bus.ABORT = 0; bus.P_READY = 0;
        model_reset();
        #1 RST_N = 1'b0;
        @(negedge CLK);
        // 1. reset with random inputs
        for (int i = 0; i < 4; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk("rst_p_out", int'(bus.P_OUT), 0);
        chk("rst_ovf",   int'(bus.OVF),   0);
        RST_N = 1'b1;
        step(0, 0, 0, 1);

        // 2. basic word 100
        step(1, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("basic_pv_early", int'(bus.P_VALID), 0);
        step(0, 1, 0, 1);
        chk("basic_p_out", int'(bus.P_OUT),   4);
        chk("basic_pv",    int'(bus.P_VALID), 1);
        step(0, 0, 0, 1);
        chk("basic_pv_drop", int'(bus.P_VALID), 0);

        // 3. gapped stream 1,1,<gap>,0
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("gap_busy", int'(bus.BUSY), 1);
        step(0, 1, 0, 1);
        chk("gap_p_out", int'(bus.P_OUT), 6);
        step(0, 0, 0, 1);

        // 4. back-to-back 011 then 101
        bits3(3'b011, 1'b1);
        chk("b2b_first", int'(bus.P_OUT), 3);
        bits3(3'b101, 1'b1);
        chk("b2b_second", int'(bus.P_OUT), 5);
        chk("b2b_pv", int'(bus.P_VALID), 1);
        step(0, 0, 0, 1);

        // 5. overflow: 011 held, 101 dropped
        bits3(3'b011, 1'b0);
        bits3(3'b101, 1'b0);
        chk("ovf_p_out", int'(bus.P_OUT), 3);
        chk("ovf_flag",  int'(bus.OVF),   1);
        step(0, 0, 0, 1);
        chk("ovf_drain_pv", int'(bus.P_VALID), 0);
        step(0, 0, 0, 1);
        chk("ovf_sticky", int'(bus.OVF), 1);

        // 6. abort mid-word
        step(1, 1, 0, 1);
        step(0, 1, 0, 1);
        step(1, 1, 1, 1);
        chk("abort_busy", int'(bus.BUSY), 0);
        bits3(3'b001, 1'b1);
        chk("abort_p_out", int'(bus.P_OUT), 1);
        chk("abort_ovf_kept", int'(bus.OVF), 1);

        // asynchronous reset between edges clears everything
        async_reset_check("arst");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset_check("arst_rand");
            step(1'($urandom),
                 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-to-parallel front end that sits directly upstream of the 3-bit parallel-load register stage. It shifts in a qualified serial bit stream MSB-first and assembles WIDTH-bit words. It presents each completed word on a held parallel output with a valid/ready handshake, so the downstream register loads only complete words. The block is double-buffered: the next word accumulates while the previous one waits for the consumer.

Parameters:
WIDTH, 3, word length in bits (legal range 1..16).
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
CLK  input  1  clock; all state changes on rising edge
RST_N  input  1  asynchronous active-low reset
SIN  input  1  serial data bit, MSB first
SIN_VALID  input  1  SIN is sampled on this edge when high
ABORT  input  1  synchronous flush of the partial word; P_OUT is not affected
P_OUT  output  WIDTH  completed parallel word, held stable while P_VALID=1
P_VALID  output  1  P_OUT holds an unconsumed word
P_READY  input  1  downstream accepts P_OUT when P_VALID&&P_READY at an edge
OVF  output  1  sticky flag: a completed word was dropped
BUSY  output  1  partial word in progress (state SHIFT)

Behaviour:
- Interface: one clock, CLK; reset RST_N is asynchronous and active-low.
- Reset (async assert, sync-safe deassert by the system): shift register=0, count=0, state=IDLE, P_OUT=0, P_VALID=0, OVF=0, BUSY=0.
- States: IDLE (count=0) and SHIFT (0<count<WIDTH). BUSY is high in SHIFT.
- IDLE: if SIN_VALID is high, shift in SIN and set count=1. Go to SHIFT, or complete the word immediately when WIDTH=1.
- SHIFT: each SIN_VALID shifts sreg <= {sreg[WIDTH-2:0], SIN} and increments count. A cycle without SIN_VALID holds state and does not time out.
- Completion edge: the edge that accepts the WIDTH-th bit. The candidate word is {sreg[WIDTH-2:0], SIN}. On that edge count returns to 0 and the state returns to IDLE.
- Output latch decision at the completion edge:
  - P_VALID=0, or P_VALID=1 and P_READY=1: P_OUT <= candidate, P_VALID <= 1. This allows back-to-back transfer with no bubble.
  - P_VALID=1 and P_READY=0: the candidate is dropped, P_OUT and P_VALID hold, OVF <= 1.
- Latency: P_VALID is visible one cycle after the cycle in which the last bit was sampled.
- Handshake: a transfer occurs at an edge with P_VALID&&P_READY. P_VALID falls the next cycle unless a word completes on that same edge. P_OUT must not change while P_VALID=1 and no transfer occurs. P_READY is ignored while P_VALID=0.
- ABORT: takes priority over SIN_VALID on the same edge. It sets count=0 and state=IDLE; the sreg content is don't-care, but the implementation clears it. P_OUT, P_VALID and OVF are unaffected. ABORT with a simultaneous transfer still completes the transfer.
- OVF is sticky. Only RST_N clears it.
- Reset mid-word or mid-handshake returns all outputs to reset values immediately and asynchronously. The partial word is lost.

Decomposition:
- Package sipo_pkg holds:
  - typedef enum logic {IDLE, SHIFT} sipo_state_t
  - localparam DEFAULT_WIDTH = 3
- Sub-module sipo_bit_counter: CNT_W counter with inc, clr and terminal-count (count==WIDTH-1 && inc) outputs. The top level holds the shift register, FSM and output buffer.

Test Plan:
All scenarios use WIDTH=3.
1. Reset: hold RST_N=0 with random inputs -> P_OUT=000, P_VALID=0, OVF=0, BUSY=0. Assert RST_N asynchronously between edges -> outputs clear without waiting for CLK.
2. Basic word: SIN_VALID=1 for 3 cycles with bits 1,0,0 and P_READY=1 -> P_OUT=100 and P_VALID=1 exactly one cycle after the third bit. P_VALID drops the following cycle.
3. Gapped stream: bits 1,1,0 with SIN_VALID low for 2 idle cycles between bits 2 and 3 -> BUSY stays high through the gap. Result P_OUT=110.
4. Back-to-back: continuous bits 0,1,1,1,0,1 with P_READY=1 -> P_OUT=011 then 101, with no P_VALID bubble at the second completion edge.
5. Overflow: word 011 completes with P_READY=0, then word 101 completes -> P_OUT stays 011 and OVF=1. Raising P_READY then transfers 011. OVF stays 1 until reset.
6. Abort: bits 1,0 then ABORT=1 together with SIN_VALID=1 -> count=0 and BUSY=0. Next bits 0,0,1 -> P_OUT=001, with the earlier bits not present.
